// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous memory between the CPU (fixed priority)
// and a DMA requester with starvation relief, locked bursts and tagged read return.
module mem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 8,
   parameter int BURST_MAX  = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_adr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_stall,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic          dma_lock,
   input  logic [AW-1:0] dma_adr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [DW-1:0] dma_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_adr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic {ARB, BURST} state_t;

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
   localparam logic [4:0] BURST_LIM  = 5'(BURST_MAX);

   state_t        state;
   logic [7:0]    starve_cnt;
   logic [3:0]    burst_cnt;
   logic          cpu_first;
   logic          cpu_gnt;
   logic          dma_sel;
   logic [4:0]    burst_next;
   logic          burst_hit;
   logic          tag_vld_p1;
   logic          tag_dma_p1;
   logic [DW-1:0] cpu_rdata_q;
   logic [DW-1:0] dma_rdata_q;

   // Grant decision: nothing is granted while reset is held.
   always_comb begin
      dma_sel = 1'b0;
      cpu_gnt = 1'b0;
      if (rst) begin
         if (state == BURST) begin
            dma_sel = dma_req;
            cpu_gnt = cpu_req && !dma_req;
         end else begin
            dma_sel = dma_req && (!cpu_req || (starve_cnt == STARVE_LIM && !cpu_first));
            cpu_gnt = cpu_req && !dma_sel;
         end
      end
   end

   assign dma_gnt   = dma_sel;
   assign cpu_stall = cpu_req && !cpu_gnt;

   always_comb begin
      mem_en    = cpu_gnt || dma_gnt;
      mem_we    = 1'b0;
      mem_adr   = '0;
      mem_wdata = '0;
      if (dma_gnt) begin
         mem_we    = dma_we;
         mem_adr   = dma_adr;
         mem_wdata = dma_wdata;
      end else if (cpu_gnt) begin
         mem_we    = cpu_we;
         mem_adr   = cpu_adr;
         mem_wdata = cpu_wdata;
      end
   end

   // Number of burst grants including the current one; a locked grant in ARB opens at 1.
   assign burst_next = (state == BURST) ? ({1'b0, burst_cnt} + 5'd1) : 5'd1;
   assign burst_hit  = (burst_next == BURST_LIM);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ARB;
         starve_cnt <= '0;
         burst_cnt  <= '0;
         cpu_first  <= 1'b0;
      end else begin
         if (dma_gnt || !dma_req)
            starve_cnt <= '0;
         else if (starve_cnt != STARVE_LIM)
            starve_cnt <= starve_cnt + 8'd1;
         cpu_first <= 1'b0;
         case (state)
            ARB: begin
               if (dma_gnt && dma_lock) begin
                  if (burst_hit) begin
                     cpu_first <= 1'b1;
                  end else begin
                     state     <= BURST;
                     burst_cnt <= 4'd1;
                  end
               end
            end
            BURST: begin
               if (!dma_gnt) begin
                  state <= ARB;
               end else if (burst_hit) begin
                  state     <= ARB;
                  cpu_first <= 1'b1;
               end else if (!dma_lock) begin
                  state <= ARB;
               end else begin
                  burst_cnt <= burst_next[3:0];
               end
            end
            default: state <= ARB;
         endcase
      end
   end

   // Stage p1: owner tag of a read granted last cycle; memory data arrives now.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tag_vld_p1 <= 1'b0;
         tag_dma_p1 <= 1'b0;
      end else begin
         tag_vld_p1 <= mem_en && !mem_we;
         tag_dma_p1 <= dma_gnt;
      end
   end

   assign cpu_rvalid = rst && tag_vld_p1 && !tag_dma_p1;
   assign dma_rvalid = rst && tag_vld_p1 && tag_dma_p1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
         if (dma_rvalid) dma_rdata_q <= mem_rdata;
      end
   end

   assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
   assign dma_rdata = dma_rvalid ? mem_rdata : dma_rdata_q;

endmodule
